// File: rtl/button_pkg.sv
// Shared state encodings and timing defaults for push-button input stages.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DOWN   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // 1 s hold and 250 ms repeat interval at 100 MHz.
  localparam int DEFAULT_HOLD_CYCLES   = 100_000_000;
  localparam int DEFAULT_REPEAT_CYCLES = 25_000_000;

  // One counter serves both the hold and the repeat interval.
  function automatic int counter_width(input int hold_cycles, input int repeat_cycles);
    int m;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event.sv
// Turns a clean button level into press/release/short/long/repeat event pulses.
// Every output is registered; the FSM decides the next pulses combinationally.
module button_event
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int CW = counter_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = (REPEAT_CYCLES == 0) ? '0 : CW'(REPEAT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          press_next, release_next, short_next, long_next, repeat_next;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (level_in) begin
          state_next = ST_DOWN;
          count_next = '0;
          press_next = 1'b1;
        end
      end
      ST_DOWN: begin
        // A release on the terminal-count edge still counts as short.
        if (!level_in) begin
          state_next   = ST_IDLE;
          release_next = 1'b1;
          short_next   = 1'b1;
        end else if (count_reg == HOLD_TC) begin
          state_next = ST_REPEAT;
          count_next = '0;
          long_next  = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!level_in) begin
          state_next   = ST_IDLE;
          release_next = 1'b1;
        end else if (REPEAT_CYCLES != 0) begin
          if (count_reg == REPEAT_TC) begin
            count_next  = '0;
            repeat_next = 1'b1;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // held tracks the registered state so it changes on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_pulse   <= short_next;
      long_pulse    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= (state_next != ST_IDLE);
      if (press_next) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Scenario bench for button_event with HOLD=4/REPEAT=3 and a REPEAT=0 build.
module tb_button_event;

  typedef struct packed {
    logic       p;
    logic       r;
    logic       s;
    logic       l;
    logic       rp;
    logic       h;
    logic [7:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, rst0;
  logic       level_in, level_in0;
  logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;
  logic       press_pulse0, release_pulse0, short_pulse0, long_pulse0, repeat_pulse0, held0;
  logic [7:0] press_count0;

  int   checks = 0;
  int   passed = 0;
  obs_t exp_q[$];
  obs_t e, got;
  logic [7:0] base;

  always #5 clk = ~clk;

  button_event #(.HOLD_CYCLES(4), .REPEAT_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .level_in(level_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held),
    .press_count(press_count)
  );

  button_event #(.HOLD_CYCLES(4), .REPEAT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .level_in(level_in0),
    .press_pulse(press_pulse0), .release_pulse(release_pulse0), .short_pulse(short_pulse0),
    .long_pulse(long_pulse0), .repeat_pulse(repeat_pulse0), .held(held0),
    .press_count(press_count0)
  );

  function automatic obs_t obs(input bit sel);
    obs_t o;
    if (sel) o = '{press_pulse0, release_pulse0, short_pulse0, long_pulse0, repeat_pulse0, held0, press_count0};
    else     o = '{press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held, press_count};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst0 = 1'b1; level_in = 1'b0; level_in0 = 1'b0;
    repeat (3) tick();
    rst = 1'b0; rst0 = 1'b0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    tick();
    got = obs(0); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL reset dut got=%h exp=%h", got, e); else passed++;
    got = obs(1); e = exp_q.pop_front(); checks++;
    if (got !== e) $display("FAIL reset dut0 got=%h exp=%h", got, e); else passed++;
    $display("reset: outputs idle");
  endtask

  task automatic test_short_press();
    base = press_count;
    for (int k = 0; k < 5; k++) begin
      level_in = (k < 2);
      exp_q.push_back('{k == 0, k == 2, k == 2, 1'b0, 1'b0, k < 2, base + 8'd1});
      tick();
      got = obs(0); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL short k=%0d got=%h exp=%h", k, got, e); else passed++;
    end
    $display("short press: count=%0d", press_count);
  endtask

  task automatic test_long_hold();
    base = press_count;
    for (int k = 0; k < 15; k++) begin
      level_in = (k < 12);
      exp_q.push_back('{k == 0, k == 12, 1'b0, k == 4, (k == 7) || (k == 10), k < 12, base + 8'd1});
      tick();
      got = obs(0); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL long k=%0d got=%h exp=%h", k, got, e); else passed++;
    end
    $display("long hold: count=%0d", press_count);
  endtask

  task automatic test_boundary();
    base = press_count;
    for (int k = 0; k < 7; k++) begin
      level_in = (k < 4);
      exp_q.push_back('{k == 0, k == 4, k == 4, 1'b0, 1'b0, k < 4, base + 8'd1});
      tick();
      got = obs(0); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL boundary k=%0d got=%h exp=%h", k, got, e); else passed++;
    end
    $display("boundary release: count=%0d", press_count);
  endtask

  task automatic test_back_to_back();
    base = press_count;
    for (int k = 0; k < 5; k++) begin
      level_in = (k == 0) || (k == 2);
      exp_q.push_back('{(k == 0) || (k == 2), (k == 1) || (k == 3), (k == 1) || (k == 3),
                        1'b0, 1'b0, (k == 0) || (k == 2), (k < 2) ? base + 8'd1 : base + 8'd2});
      tick();
      got = obs(0); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, e); else passed++;
    end
    $display("back to back: count=%0d", press_count);
  endtask

  task automatic test_reset_mid_hold();
    base = press_count;
    for (int k = 0; k < 7; k++) begin
      level_in = (k < 5);
      rst = (k == 2);
      case (k)
        0:       exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, base + 8'd1});
        1:       exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, base + 8'd1});
        2:       exp_q.push_back('0);
        3:       exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        4:       exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        5:       exp_q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
        default: exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});
      endcase
      tick();
      got = obs(0); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL reset_mid_hold k=%0d got=%h exp=%h", k, got, e); else passed++;
    end
    rst = 1'b0;
    $display("reset mid-hold: count=%0d", press_count);
  endtask

  task automatic test_wrap();
    rst = 1'b1; level_in = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      level_in = 1'b1;
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i + 1)});
      tick();
      got = obs(0); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL wrap i=%0d got=%h exp=%h", i, got, e); else passed++;
      level_in = 1'b0;
      tick();
    end
    checks++;
    if (press_count !== 8'd0) $display("FAIL wrap_final got=%0d exp=0", press_count); else passed++;
    $display("wrap: 256 presses, count=%0d", press_count);
  endtask

  task automatic test_repeat_disabled();
    int longs = 0;
    int repeats = 0;
    for (int k = 0; k < 22; k++) begin
      level_in0 = (k < 20);
      exp_q.push_back('{k == 0, k == 20, 1'b0, k == 4, 1'b0, k < 20, 8'd1});
      tick();
      got = obs(1); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL norepeat k=%0d got=%h exp=%h", k, got, e); else passed++;
      longs += int'(long_pulse0);
      repeats += int'(repeat_pulse0);
    end
    checks++;
    if (longs !== 1 || repeats !== 0)
      $display("FAIL norepeat_totals got long=%0d repeat=%0d exp long=1 repeat=0", longs, repeats);
    else passed++;
    $display("repeat disabled: long=%0d repeat=%0d", longs, repeats);
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_boundary();
    test_back_to_back();
    test_reset_mid_hold();
    test_wrap();
    test_repeat_disabled();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter HOLD_CYCLES, default 100_000_000, clk cycles from press to long_pulse (1 s at 100 MHz); SHALL be >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 25_000_000, clk cycles between repeat_pulse events; 0 SHALL disable auto-repeat.
REQ-003 Port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port level_in, input, 1, conditioned button level from generic_input named_output, already synchronous to clk; 1 = pressed.
REQ-006 Port press_pulse, output, 1, one-cycle pulse on press.
REQ-007 Port release_pulse, output, 1, one-cycle pulse on any release.
REQ-008 Port short_pulse, output, 1, one-cycle pulse on release before long threshold.
REQ-009 Port long_pulse, output, 1, one-cycle pulse when hold reaches HOLD_CYCLES.
REQ-010 Port repeat_pulse, output, 1, one-cycle pulse every REPEAT_CYCLES after long_pulse while held.
REQ-011 Port held, output, 1, high while FSM is not IDLE.
REQ-012 Port press_count, output, 8, running count of presses.

Function
REQ-013 All outputs SHALL be registered; no combinational path from level_in to any output.
REQ-014 FSM states SHALL be IDLE, DOWN, REPEAT; one hold/repeat counter, width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
REQ-015 IDLE with level_in=1 at an edge: go DOWN, counter<=0, press_pulse=1 next cycle, press_count increments by 1 (wrap 255->0).
REQ-016 DOWN with level_in=1 and counter!=HOLD_CYCLES-1: counter increments.
REQ-017 DOWN with level_in=1 and counter==HOLD_CYCLES-1: go REPEAT, counter<=0, long_pulse=1; long_pulse SHALL fire exactly HOLD_CYCLES edges after the press_pulse edge.
REQ-018 DOWN with level_in=0: go IDLE, release_pulse=1 and short_pulse=1 same cycle; release at the terminal-count edge SHALL win (short_pulse, no long_pulse).
REQ-019 REPEAT with level_in=1, REPEAT_CYCLES!=0: counter increments; at counter==REPEAT_CYCLES-1 repeat_pulse=1 and counter<=0 (repeat every REPEAT_CYCLES edges).
REQ-020 REPEAT with REPEAT_CYCLES=0: counter frozen, repeat_pulse never asserted.
REQ-021 REPEAT with level_in=0: go IDLE, release_pulse=1, short_pulse=0; release at repeat terminal edge SHALL suppress repeat_pulse.
REQ-022 Pulses SHALL deassert the cycle after assertion; at most one of press/long/repeat/release per cycle.
REQ-023 held SHALL be 1 in DOWN and REPEAT, 0 in IDLE, updating on the same edge as the state.
REQ-024 Counter SHALL never exceed its terminal value; no wrap inside a state.

Reset
REQ-025 rst sampled high at an edge SHALL force IDLE, counter=0, all pulses=0, held=0, press_count=0, overriding all other transitions.
REQ-026 Reset mid-hold: after rst deasserts with level_in still 1, the next edge SHALL be treated as a new press (press_pulse, press_count=1).

Structure
REQ-027 State encodings (IDLE=2'd0, DOWN=2'd1, REPEAT=2'd2) and default timing constants SHALL live in shared package button_pkg for reuse by other input stages.
REQ-028 Single flat module, no sub-module; one FSM always-block plus one output-register block.

Verification (HOLD_CYCLES=4, REPEAT_CYCLES=3)
REQ-029 Short press: level_in high 2 cycles -> press_pulse at edge E, release_pulse+short_pulse at E+2, no long_pulse, press_count=1.
REQ-030 Long hold: level_in high 12 cycles -> long_pulse at E+4, repeat_pulse at E+7 and E+10, release_pulse only (no short_pulse) on release.
REQ-031 Boundary: level_in sampled 0 exactly at E+4 -> short_pulse+release_pulse at E+4, long_pulse never asserted.
REQ-032 Reset mid-hold: rst at E+2 with level_in held -> all outputs 0, held=0; first edge after rst -> press_pulse, press_count=1.
REQ-033 Wrap: 256 short presses -> press_count reads 0; REPEAT_CYCLES=0 build held 20 cycles -> one long_pulse, zero repeat_pulse.
